// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Sequences the hydrophone capture path. It counts ADC sample strobes,
//   watches the FFT trigger, and after POST_SAMPLES post-trigger samples
//   requests exactly one FRAME_LEN-clock frame from the ring buffer. It then
//   ignores HOLDOFF_SAMPLES samples before re-arming (continuous) or idling.
//
//   Optional build macro: CAPTURE_SEQ_WATCHDOG_EN
//     When defined, POST or HOLDOFF faults after TIMEOUT_CLKS clocks without
//     a sample edge. When undefined, both states wait indefinitely.
//
// Ports
//   clk, reset        system clock; synchronous active-high reset
//   arm, disarm       one-clock control pulses
//   continuous        level: after hold-off re-arm (1) or idle (0)
//   sample_ready      raw SPI data-ready level; one sample per rising edge
//   trigger           FFT trigger level; a rising edge is the event
//   ram_overflow      ring buffer overflow flag
//   send_frame        frame request to the ring buffer
//   frame_index       word index during SEND (0 outside SEND)
//   frame_last        high on the final SEND clock
//   armed/busy/fault  state decodes (busy = POST, SEND or HOLDOFF)
//   state             IDLE=0 ARMED=1 POST=2 SEND=3 HOLDOFF=4 FAULT=5
//   trigger_count     accepted triggers, saturating at 0xFFFF
// All outputs are registered.

module capture_sequencer #(
    parameter int POST_SAMPLES    = 128,
    parameter int FRAME_LEN       = 256,
    parameter int HOLDOFF_SAMPLES = 512,
    parameter int TIMEOUT_CLKS    = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         disarm,
    input  logic                         continuous,
    input  logic                         sample_ready,
    input  logic                         trigger,
    input  logic                         ram_overflow,
    output logic                         send_frame,
    output logic [$clog2(FRAME_LEN)-1:0] frame_index,
    output logic                         frame_last,
    output logic                         armed,
    output logic                         busy,
    output logic                         fault,
    output logic [2:0]                   state,
    output logic [15:0]                  trigger_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_POST    = 3'd2,
        S_SEND    = 3'd3,
        S_HOLDOFF = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam int IW   = $clog2(FRAME_LEN);
    localparam int SMAX = (POST_SAMPLES > HOLDOFF_SAMPLES) ? POST_SAMPLES : HOLDOFF_SAMPLES;
    localparam int CW   = (SMAX > 0) ? $clog2(SMAX + 1) : 1;

    localparam logic [CW-1:0] POST_LAST  = CW'(POST_SAMPLES);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_SAMPLES);
    localparam logic [IW-1:0] INDEX_LAST = IW'(FRAME_LEN - 1);

    if (FRAME_LEN < 2 || (FRAME_LEN & (FRAME_LEN - 1)) != 0 || TIMEOUT_CLKS < 1) begin : g_param_check
        $error("capture_sequencer: FRAME_LEN must be a power of two >= 2 and TIMEOUT_CLKS >= 1");
    end

    state_t          state_q, state_n;
    logic            sample_q, sample_d, trig_q, trig_d;
    logic            sample_edge, trig_edge;
    logic [CW-1:0]   sample_cnt, cnt_n, cnt_inc;
    logic [IW-1:0]   index_n;
    logic [15:0]     tcount_n;
    logic            stop_q, stop_n;   // disarm seen during SEND: finish, then idle

`ifdef CAPTURE_SEQ_WATCHDOG_EN
    localparam int            WW      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CLKS);
    logic [WW-1:0] wd_cnt, wd_n, wd_inc;
`endif

    // Inputs are registered once; an edge is the registered value rising
    // relative to its own previous cycle.
    assign sample_edge = sample_q & ~sample_d;
    assign trig_edge   = trig_q & ~trig_d;
    assign state       = state_q;

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n  = state_q;
        cnt_n    = sample_cnt;
        cnt_inc  = sample_cnt + CW'(1);
        index_n  = '0;
        tcount_n = trigger_count;
        stop_n   = stop_q;
`ifdef CAPTURE_SEQ_WATCHDOG_EN
        wd_n     = '0;
        wd_inc   = wd_cnt + WW'(1);
`endif
        if (ram_overflow && state_q != S_IDLE) begin
            state_n = S_FAULT;
            stop_n  = 1'b0;
        end else if (disarm && state_q != S_SEND) begin
            state_n = S_IDLE;
            stop_n  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) state_n = S_ARMED;
                end
                S_FAULT: begin
                    if (arm) begin
                        state_n  = S_ARMED;
                        cnt_n    = '0;
                        tcount_n = '0;
                    end
                end
                S_ARMED: begin
                    // A sample edge coinciding with the trigger is not counted:
                    // the count restarts from zero on entry to POST.
                    if (trig_edge) begin
                        tcount_n = (trigger_count == 16'hFFFF) ? trigger_count
                                                               : trigger_count + 16'd1;
                        cnt_n    = '0;
                        state_n  = (POST_SAMPLES == 0) ? S_SEND : S_POST;
                    end
                end
                S_POST: begin
                    if (sample_edge) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == POST_LAST) state_n = S_SEND;
                    end
`ifdef CAPTURE_SEQ_WATCHDOG_EN
                    else if (wd_inc == WD_LAST) state_n = S_FAULT;
                    else wd_n = wd_inc;
`endif
                end
                S_SEND: begin
                    if (disarm) stop_n = 1'b1;
                    if (frame_index == INDEX_LAST) begin
                        cnt_n  = '0;
                        stop_n = 1'b0;
                        if (stop_q || disarm)      state_n = S_IDLE;
                        else if (HOLDOFF_SAMPLES == 0) state_n = continuous ? S_ARMED : S_IDLE;
                        else                        state_n = S_HOLDOFF;
                    end else begin
                        index_n = frame_index + IW'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (sample_edge) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == HOLD_LAST) state_n = continuous ? S_ARMED : S_IDLE;
                    end
`ifdef CAPTURE_SEQ_WATCHDOG_EN
                    else if (wd_inc == WD_LAST) state_n = S_FAULT;
                    else wd_n = wd_inc;
`endif
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            sample_q      <= 1'b0;
            sample_d      <= 1'b0;
            trig_q        <= 1'b0;
            trig_d        <= 1'b0;
            sample_cnt    <= '0;
            stop_q        <= 1'b0;
            trigger_count <= '0;
            frame_index   <= '0;
            send_frame    <= 1'b0;
            frame_last    <= 1'b0;
            armed         <= 1'b0;
            busy          <= 1'b0;
            fault         <= 1'b0;
`ifdef CAPTURE_SEQ_WATCHDOG_EN
            wd_cnt        <= '0;
`endif
        end else begin
            state_q       <= state_n;
            sample_q      <= sample_ready;
            sample_d      <= sample_q;
            trig_q        <= trigger;
            trig_d        <= trig_q;
            sample_cnt    <= cnt_n;
            stop_q        <= stop_n;
            trigger_count <= tcount_n;
            frame_index   <= index_n;
            send_frame    <= (state_n == S_SEND);
            frame_last    <= (state_n == S_SEND) && (index_n == INDEX_LAST);
            armed         <= (state_n == S_ARMED);
            busy          <= (state_n == S_POST) || (state_n == S_SEND) || (state_n == S_HOLDOFF);
            fault         <= (state_n == S_FAULT);
`ifdef CAPTURE_SEQ_WATCHDOG_EN
            wd_cnt        <= wd_n;
`endif
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer. Instance "a" uses the default parameters,
// instance "b" uses POST_SAMPLES=0, HOLDOFF_SAMPLES=0, FRAME_LEN=8.
// A behavioural model tracks each instance and all outputs are compared on
// every negative clock edge; directed sequences add literal expectations.

module tb_capture_sequencer;

    localparam int M_IDLE = 0, M_ARMED = 1, M_POST = 2, M_SEND = 3, M_HOLDOFF = 4, M_FAULT = 5;

    typedef struct {
        int st;
        int left;
        int pos;
        bit stop;
        int tcnt;
        int quiet;
        bit s_q, s_d, t_q, t_d;
    } model_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // instance a
    logic arm_a = 0, disarm_a = 0, cont_a = 0, sr_a = 0, trig_a = 0, ovf_a = 0;
    logic send_a, last_a, armed_a, busy_a, fault_a;
    logic [7:0] index_a;
    logic [2:0] state_a;
    logic [15:0] tcnt_a;

    // instance b
    logic arm_b = 0, disarm_b = 0, cont_b = 0, sr_b = 0, trig_b = 0, ovf_b = 0;
    logic send_b, last_b, armed_b, busy_b, fault_b;
    logic [2:0] index_b;
    logic [2:0] state_b;
    logic [15:0] tcnt_b;

    capture_sequencer dut_a (
        .clk(clk), .reset(reset), .arm(arm_a), .disarm(disarm_a), .continuous(cont_a),
        .sample_ready(sr_a), .trigger(trig_a), .ram_overflow(ovf_a),
        .send_frame(send_a), .frame_index(index_a), .frame_last(last_a),
        .armed(armed_a), .busy(busy_a), .fault(fault_a), .state(state_a),
        .trigger_count(tcnt_a)
    );

    capture_sequencer #(.POST_SAMPLES(0), .FRAME_LEN(8), .HOLDOFF_SAMPLES(0)) dut_b (
        .clk(clk), .reset(reset), .arm(arm_b), .disarm(disarm_b), .continuous(cont_b),
        .sample_ready(sr_b), .trigger(trig_b), .ram_overflow(ovf_b),
        .send_frame(send_b), .frame_index(index_b), .frame_last(last_b),
        .armed(armed_b), .busy(busy_b), .fault(fault_b), .state(state_b),
        .trigger_count(tcnt_b)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic model_t model_reset();
        model_t m;
        m.st = M_IDLE; m.left = 0; m.pos = 0; m.stop = 0; m.tcnt = 0; m.quiet = 0;
        m.s_q = 0; m.s_d = 0; m.t_q = 0; m.t_d = 0;
        return m;
    endfunction

    function automatic int after_frame(bit cont);
        return cont ? M_ARMED : M_IDLE;
    endfunction

    function automatic model_t model_next(model_t m, bit rst, bit arm_i, bit dis, bit cont,
                                          bit sr, bit tr, bit ovf, int ps, int fl, int hs, int to);
        model_t n;
        bit se, te;
        if (rst) return model_reset();
        n = m;
        se = m.s_q && !m.s_d;
        te = m.t_q && !m.t_d;
        n.s_d = m.s_q; n.s_q = sr;
        n.t_d = m.t_q; n.t_q = tr;
        n.pos = 0;
        if (ovf && m.st != M_IDLE) begin
            n.st = M_FAULT; n.stop = 0;
        end else if (dis && m.st != M_SEND) begin
            n.st = M_IDLE; n.stop = 0;
        end else begin
            case (m.st)
                M_IDLE:  if (arm_i) n.st = M_ARMED;
                M_FAULT: if (arm_i) begin n.st = M_ARMED; n.tcnt = 0; end
                M_ARMED: if (te) begin
                    n.tcnt = (m.tcnt < 65535) ? m.tcnt + 1 : 65535;
                    if (ps == 0) n.st = M_SEND;
                    else begin n.st = M_POST; n.left = ps; n.quiet = 0; end
                end
                M_POST: begin
                    if (se) begin
                        n.left = m.left - 1; n.quiet = 0;
                        if (n.left == 0) n.st = M_SEND;
                    end
`ifdef CAPTURE_SEQ_WATCHDOG_EN
                    else if (m.quiet + 1 >= to) n.st = M_FAULT;
                    else n.quiet = m.quiet + 1;
`endif
                end
                M_SEND: begin
                    if (m.pos == fl - 1) begin
                        n.stop = 0;
                        if (m.stop || dis) n.st = M_IDLE;
                        else if (hs == 0) n.st = after_frame(cont);
                        else begin n.st = M_HOLDOFF; n.left = hs; n.quiet = 0; end
                    end else begin
                        n.pos = m.pos + 1;
                        if (dis) n.stop = 1;
                    end
                end
                M_HOLDOFF: begin
                    if (se) begin
                        n.left = m.left - 1; n.quiet = 0;
                        if (n.left == 0) n.st = after_frame(cont);
                    end
`ifdef CAPTURE_SEQ_WATCHDOG_EN
                    else if (m.quiet + 1 >= to) n.st = M_FAULT;
                    else n.quiet = m.quiet + 1;
`endif
                end
                default: n.st = M_IDLE;
            endcase
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_vec(model_t m, int fl);
        logic sending;
        sending = (m.st == M_SEND);
        return {3'(m.st), sending, 8'(m.pos), sending && (m.pos == fl - 1),
                m.st == M_ARMED, (m.st == M_POST) || sending || (m.st == M_HOLDOFF),
                m.st == M_FAULT, 16'(m.tcnt)};
    endfunction

    model_t ma, mb;
    initial begin
        ma = model_reset();
        mb = model_reset();
    end

    always @(posedge clk) begin
        ma <= model_next(ma, reset, arm_a, disarm_a, cont_a, sr_a, trig_a, ovf_a, 128, 256, 512, 4096);
        mb <= model_next(mb, reset, arm_b, disarm_b, cont_b, sr_b, trig_b, ovf_b, 0, 8, 0, 4096);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_a", {state_a, send_a, index_a, last_a, armed_a, busy_a, fault_a, tcnt_a},
                  exp_vec(ma, 256));
            check("model_b", {state_b, send_b, 5'd0, index_b, last_b, armed_b, busy_b, fault_b, tcnt_b},
                  exp_vec(mb, 8));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_samples(input int n);
        repeat (n) begin
            sr_a = 1; tick(2);
            sr_a = 0; tick(2);
        end
    endtask

    task automatic fire_trigger();
        trig_a = 1; tick(2);
        trig_a = 0;
    endtask

    task automatic pulse_arm();
        arm_a = 1; tick(1); arm_a = 0;
    endtask

    task automatic wait_index(input int target, input int budget);
        int n = 0;
        while (index_a != 8'(target) && n < budget) begin tick(1); n++; end
        check("wait_index", 32'(index_a == 8'(target)), 32'd1);
    endtask

    task automatic wait_last(input int budget);
        int n = 0;
        while (last_a !== 1'b1 && n < budget) begin tick(1); n++; end
        check("wait_last", 32'(last_a), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- reset, one-shot frame ----
        reset = 1; tick(1); cmp_en = 1; tick(2);
        reset = 0; tick(1);
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_send", 32'(send_a), 32'd0);
        check("rst_tcnt", 32'(tcnt_a), 32'd0);
        pulse_arm();
        check("arm_state", 32'(state_a), 32'd1);
        trig_a = 1; tick(1);
        check("trig_t1_state", 32'(state_a), 32'd1);
        tick(1);
        check("trig_t2_state", 32'(state_a), 32'd2);
        trig_a = 0;
        pulse_samples(127);
        sr_a = 1; tick(1);
        check("s_edge_send", 32'(send_a), 32'd0);
        tick(1);
        check("s1_send", 32'(send_a), 32'd1);
        check("s1_index", 32'(index_a), 32'd0);
        sr_a = 0; tick(255);
        check("last_flag", 32'(last_a), 32'd1);
        check("last_index", 32'(index_a), 32'd255);
        check("last_send", 32'(send_a), 32'd1);
        tick(1);
        check("post_frame_send", 32'(send_a), 32'd0);
        check("post_frame_state", 32'(state_a), 32'd4);
        check("one_trigger", 32'(tcnt_a), 32'd1);
        pulse_samples(511);
        check("holdoff_511", 32'(state_a), 32'd4);
        sr_a = 1; tick(2);
        check("holdoff_idle", 32'(state_a), 32'd0);
        sr_a = 0; tick(2);

        // ---- continuous, trigger during hold-off ignored ----
        reset = 1; tick(2); reset = 0; tick(1);
        check("rst2_tcnt", 32'(tcnt_a), 32'd0);
        cont_a = 1;
        pulse_arm();
        fire_trigger();
        pulse_samples(128);
        tick(260);
        check("c1_holdoff", 32'(state_a), 32'd4);
        fire_trigger();
        tick(1);
        check("c_ignored_tcnt", 32'(tcnt_a), 32'd1);
        pulse_samples(512);
        check("c_rearmed", 32'(state_a), 32'd1);
        fire_trigger();
        pulse_samples(128);
        tick(260);
        check("c2_tcnt", 32'(tcnt_a), 32'd2);
        disarm_a = 1; tick(1); disarm_a = 0;
        check("holdoff_disarm", 32'(state_a), 32'd0);
        cont_a = 0;

        // ---- overflow abort ----
        pulse_arm();
        fire_trigger();
        pulse_samples(128);
        check("ovf_pre_tcnt", 32'(tcnt_a), 32'd3);
        wait_index(40, 400);
        ovf_a = 1; tick(1); ovf_a = 0;
        check("ovf_send", 32'(send_a), 32'd0);
        check("ovf_state", 32'(state_a), 32'd5);
        pulse_arm();
        check("fault_arm_state", 32'(state_a), 32'd1);
        check("fault_arm_tcnt", 32'(tcnt_a), 32'd0);

        // ---- disarm mid-SEND completes the frame ----
        fire_trigger();
        pulse_samples(128);
        wait_index(100, 400);
        disarm_a = 1; tick(1); disarm_a = 0;
        check("dis_send_on", 32'(send_a), 32'd1);
        wait_last(300);
        check("dis_last_index", 32'(index_a), 32'd255);
        tick(1);
        check("dis_end_state", 32'(state_a), 32'd0);
        check("dis_end_send", 32'(send_a), 32'd0);
        arm_a = 1; disarm_a = 1; tick(1); arm_a = 0; disarm_a = 0;
        check("arm_dis_idle", 32'(state_a), 32'd0);

        // ---- zero post/hold-off instance ----
        cont_b = 1;
        arm_b = 1; tick(1); arm_b = 0; tick(1);
        trig_b = 1; tick(1);
        check("b_t1_send", 32'(send_b), 32'd0);
        tick(1);
        check("b_t2_send", 32'(send_b), 32'd1);
        check("b_t2_state", 32'(state_b), 32'd3);
        trig_b = 0; tick(7);
        check("b_last", 32'(last_b), 32'd1);
        check("b_last_index", 32'(index_b), 32'd7);
        trig_b = 1; tick(1);
        check("b_gap_send", 32'(send_b), 32'd0);
        check("b_gap_state", 32'(state_b), 32'd1);
        tick(1);
        check("b_again_send", 32'(send_b), 32'd1);
        trig_b = 0; tick(8);
        check("b_end_state", 32'(state_b), 32'd1);
        check("b_tcnt", 32'(tcnt_b), 32'd2);

        // ---- sample starvation in POST ----
        pulse_arm();
        fire_trigger();
        check("starve_post", 32'(state_a), 32'd2);
`ifdef CAPTURE_SEQ_WATCHDOG_EN
        tick(4095);
        check("wd_before", 32'(state_a), 32'd2);
        tick(1);
        check("wd_fault", 32'(state_a), 32'd5);
`else
        tick(10000);
        check("no_wd_post", 32'(state_a), 32'd2);
`endif

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

- Sequences the hydrophone capture path: ring buffer, trigger FFT and downstream frame consumer.
- Counts incoming ADC sample strobes and watches the FFT trigger.
- After a programmable number of post-trigger samples, asserts `send_frame` to the ring buffer for exactly one frame, then enforces a hold-off before re-arming.
- Sits between the SPI sample front end, the ring buffer and the trigger FFT, replacing the ad-hoc `send_frame` drive.

## Interface
Parameters:
- `POST_SAMPLES`, 128: sample strobes counted after an accepted trigger before the frame is sent (0 allowed).
- `FRAME_LEN`, 256: clocks `send_frame` stays high; power of two, ≥2.
- `HOLDOFF_SAMPLES`, 512: sample strobes ignored after a frame before re-arm (0 allowed).
- `TIMEOUT_CLKS`, 4096: watchdog limit; used only with the watchdog compiled in.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous and active-high.
- `arm`  in  1  one-clock pulse; IDLE/FAULT -> ARMED.
- `disarm`  in  1  one-clock pulse; return to IDLE.
- `continuous`  in  1  level; after hold-off go to ARMED (1) or IDLE (0).
- `sample_ready`  in  1  raw SPI data-ready level, multi-clock; one sample per rising edge.
- `trigger`  in  1  FFT trigger level; a rising edge is the event.
- `ram_overflow`  in  1  ring buffer overflow flag.
- `send_frame`  out  1  frame request to ring buffer.
- `frame_index`  out  log2(FRAME_LEN)  word index during SEND.
- `frame_last`  out  1  high on final SEND clock.
- `armed`  out  1  state == ARMED.
- `busy`  out  1  state is POST, SEND or HOLDOFF.
- `fault`  out  1  state == FAULT.
- `state`  out  3  IDLE=0, ARMED=1, POST=2, SEND=3, HOLDOFF=4, FAULT=5.
- `trigger_count`  out  16  accepted triggers, saturates at 0xFFFF.

## Operation
- Edge detect: `sample_ready` and `trigger` are registered once. An edge is seen in cycle N when the registered value is 1 at N and was 0 at N-1. Both edge registers reset to 0.
- IDLE: outputs idle. `arm` -> ARMED.
- ARMED: trigger edge -> `trigger_count`+1, go to POST; go to SEND if `POST_SAMPLES`=0. A sample edge in the same cycle as the trigger edge is not counted.
- POST: counts sample edges. On the `POST_SAMPLES`-th edge -> SEND.
- SEND: `send_frame`=1 for exactly `FRAME_LEN` clocks. `frame_index` runs 0..`FRAME_LEN`-1 and wraps to 0 on exit. `frame_last` is high with index `FRAME_LEN`-1. Then -> HOLDOFF, or directly to ARMED/IDLE if `HOLDOFF_SAMPLES`=0.
- HOLDOFF: counts sample edges. On the `HOLDOFF_SAMPLES`-th edge -> ARMED if `continuous`, else IDLE. Triggers are ignored and not counted.
- Overflow: `ram_overflow`=1 in any state except IDLE -> FAULT.
  - In SEND the frame is aborted: `send_frame` falls the next clock.
  - In FAULT, `arm` -> ARMED (counters cleared) and `disarm` -> IDLE.
- Disarm:
  - In ARMED, POST or HOLDOFF -> IDLE.
  - In SEND the frame completes, then -> IDLE with no hold-off.
- Priority in the same cycle: `ram_overflow` > `disarm` > `arm` > trigger/sample events.
- `arm` while busy or armed is ignored.
- Reset: all outputs and counters are 0, state IDLE. Reset mid-SEND drops `send_frame` the next clock.

## Timing
- All outputs are registered.
- Trigger rising at input in cycle T: registered edge at T+1, `state`=POST at T+2.
- With `POST_SAMPLES`=0: `send_frame` first high at T+2.
- From the final counted sample edge in cycle S: `send_frame`=1 at S+1 through S+`FRAME_LEN`.
- `send_frame` never exceeds `FRAME_LEN` consecutive clocks. Back-to-back frames are separated by at least one low clock.
- Counters are sized ceil(log2(max(param)+1)) and compared for equality, with no off-by-one.

## Configuration
- `CAPTURE_SEQ_WATCHDOG_EN` defined:
  - In POST or HOLDOFF, a clock counter resets on every sample edge.
  - Reaching `TIMEOUT_CLKS` clocks without a sample edge -> FAULT.
- Undefined: POST and HOLDOFF wait indefinitely for samples, and `TIMEOUT_CLKS` is unused.

## Test plan
- Reset then `arm`, trigger edge, 128 sample edges -> `send_frame` high exactly 256 clocks starting 1 clock after the 128th edge; `frame_last` at index 255; `trigger_count`=1.
- `continuous`=1, three triggers, including one during HOLDOFF -> two frames; `trigger_count`=2; state returns to ARMED after 512 edges.
- `ram_overflow` pulse at `frame_index`=40 -> `send_frame` low the next clock; `state`=5; `arm` -> state 1 with counters zero.
- `disarm` mid-SEND -> frame finishes all 256 clocks, then `state`=0 with no HOLDOFF. `disarm` and `arm` in the same cycle from IDLE -> stays IDLE.
- `POST_SAMPLES`=0, `HOLDOFF_SAMPLES`=0 -> `send_frame` high at T+2, then ARMED immediately after `frame_last`.
- With `CAPTURE_SEQ_WATCHDOG_EN` and `TIMEOUT_CLKS`=4096: stop `sample_ready` in POST -> FAULT after 4096 clocks. Without the macro -> still POST after 10000 clocks.
